// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding HI/LO, busy for a fixed latency per op.
// Defining MDU_MADD_EN enables madd/maddu (accumulate into {HI,LO}); otherwise those codes are no-ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUsel,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic pwr_q, pwr_d, busy_q, busy_d;
  logic is_madd, is_mul, sgn_mul, is_div, a_neg, b_neg, done, accept;
  logic [63:0] a_ext, b_ext, prod, base, sum;
  logic [31:0] ua, ub, uq, ur, quo, rem;
`ifdef MDU_MADD_EN
  assign is_madd = MDUsel == 4'd7 || MDUsel == 4'd8;
`else
  assign is_madd = 1'b0;
`endif
  assign is_mul  = MDUsel == 4'd1 || MDUsel == 4'd2 || is_madd;
  assign sgn_mul = MDUsel == 4'd1 || MDUsel == 4'd7;
  assign is_div  = MDUsel == 4'd3 || MDUsel == 4'd4;
  assign a_ext   = {{32{sgn_mul & A[31]}}, A};
  assign b_ext   = {{32{sgn_mul & B[31]}}, B};
  assign prod    = a_ext * b_ext;
  // An accumulate accepted on the completing edge must see the result being retired.
  assign base    = done && pwr_q ? {phi_q, plo_q} : {hi_q, lo_q};
  assign sum     = base + prod;
  assign a_neg   = MDUsel == 4'd3 && A[31];
  assign b_neg   = MDUsel == 4'd3 && B[31];
  assign ua      = a_neg ? -A : A;
  assign ub      = b_neg ? -B : B;
  assign uq      = ub == '0 ? '0 : ua / ub;
  assign ur      = ub == '0 ? '0 : ua % ub;
  assign quo     = a_neg ^ b_neg ? -uq : uq;
  assign rem     = a_neg ? -ur : ur;
  assign done    = state_q == RUN && cnt_q == CW'(1);
  // The completing edge also accepts, so a stalled request issues back-to-back.
  assign accept  = start && (state_q == IDLE || done);
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == RUN ? cnt_q - CW'(1) : cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    busy_d  = busy_q;
    if (done) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      hi_d    = pwr_q ? phi_q : hi_q;
      lo_d    = pwr_q ? plo_q : lo_q;
    end
    if (accept && MDUsel == 4'd5) hi_d = A;
    if (accept && MDUsel == 4'd6) lo_d = A;
    if (accept && (is_mul || is_div)) begin
      state_d = RUN;
      busy_d  = 1'b1;
      cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      pwr_d   = is_mul || B != '0;
      phi_d   = is_mul ? (is_madd ? sum[63:32] : prod[63:32]) : rem;
      plo_d   = is_mul ? (is_madd ? sum[31:0] : prod[31:0]) : quo;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
      busy_q  <= busy_d;
    end
  end
  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; queued expectations are retired when the busy window of each op ends.
module tb_mdu;
  logic clk = 1'b0, reset, start, busy;
  logic [31:0] A, B, HI, LO;
  logic [3:0] MDUsel;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int n; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t q[$];

  mdu dut (.clk(clk), .reset(reset), .A(A), .B(B), .MDUsel(MDUsel), .start(start),
           .busy(busy), .HI(HI), .LO(LO));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUsel = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUsel = 4'd0; A = $urandom; B = $urandom;
  endtask

  task automatic push(input int n, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.n = n; e.hi = hi; e.lo = lo;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_wait", {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic rst_at;
    rst_at = reset;
    #1;
    if (rst_at) begin
      q.delete();
      cyc = 0;
    end else if (q.size() > 0 && cyc == q[0].n) begin
      check("result_hi", HI, q[0].hi);
      check("result_lo", LO, q[0].lo);
      void'(q.pop_front());
      cyc = busy ? 1 : 0;
    end else if (busy) begin
      cyc++;
      if (q.size() == 0) check("unexpected_busy", {31'b0, busy}, 32'd0);
    end else if (cyc != 0) begin
      check("busy_length", cyc, q.size() > 0 ? q[0].n : 0);
      cyc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; MDUsel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    push(5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    launch(4'd1, 32'hFFFFFFFF, 32'h2);
    wait_idle();
    push(5, 32'h00000001, 32'hFFFFFFFE);
    launch(4'd2, 32'hFFFFFFFF, 32'h2);
    wait_idle();
    push(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(4'd3, 32'hFFFFFFF9, 32'h2);
    wait_idle();
    push(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(4'd4, 32'd7, 32'd0);
    wait_idle();
    launch(4'd5, 32'h12345678, 32'h0);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    push(10, 32'd6, 32'd142);
    launch(4'd3, 32'd1000, 32'd7);
    launch(4'd6, 32'hCAFEF00D, 32'h0);
    wait_idle();
    check("mtlo_ignored", LO, 32'd142);
    push(10, 32'd1, 32'd33);
    launch(4'd3, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_hi_late", HI, 32'd0);
    check("abort_lo_late", LO, 32'd0);
    push(10, 32'h0, 32'h80000000);
    launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (8) @(negedge clk);
    push(5, 32'h1, 32'h0);
    launch(4'd1, 32'h00010000, 32'h00010000);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    launch(4'd6, 32'd5, 32'h0);
    launch(4'd5, 32'd0, 32'h0);
    check("pre_madd_lo", LO, 32'd5);
`ifdef MDU_MADD_EN
    push(5, 32'd0, 32'd17);
    launch(4'd7, 32'd3, 32'd4);
    wait_idle();
`else
    launch(4'd7, 32'd3, 32'd4);
    check("madd_off_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("madd_off_lo", LO, 32'd5);
    check("madd_off_hi", HI, 32'd0);
`endif
    launch(4'hF, 32'hDEADBEEF, 32'h1);
    check("reserved_busy", {31'b0, busy}, 32'd0);
    check("reserved_hi", HI, 32'd0);
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
